// File: rtl/vr_elastic_node.sv
// ---------------------------------------------------------------------------
// vr_elastic_node
//
// DEPTH-entry elastic buffer on a valid/ready link. It sustains one transfer
// per cycle at any DEPTH >= 2, and every output comes straight from a flop, so
// there is no combinational path from an input to an output.
//
// Parameters
//   WIDTH : payload width in bits (>= 1)
//   DEPTH : number of storage entries (>= 2, need not be a power of two)
//   CW    : occupancy counter width, derived from DEPTH (do not override)
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   flush          : synchronous clear of all buffered entries (wins over fires)
//   data_in        : upstream payload
//   valid_up_in    : upstream valid
//   ready_up_out   : ready to upstream (registered)
//   data_out       : downstream payload (registered, stable while stalled)
//   valid_down_out : valid to downstream (registered)
//   ready_down_in  : downstream ready
//   occupancy      : current entry count; exists only when VR_NODE_OCC_EN is
//                    defined
//
// Optional feature macro: VR_NODE_OCC_EN (adds the occupancy port).
// ---------------------------------------------------------------------------
module vr_elastic_node #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    output logic             ready_up_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    input  logic             ready_down_in
`ifdef VR_NODE_OCC_EN
    ,
    output logic [CW-1:0]    occupancy
`endif
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    wr_ptr_inc, rd_ptr_inc;
    logic [CW-1:0]    count, count_next;
    logic             up_fire, down_fire;

    always_comb begin
        up_fire   = valid_up_in & ready_up_out;
        down_fire = valid_down_out & ready_down_in;

        // Explicit wrap so non-power-of-two depths work.
        wr_ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        rd_ptr_inc = (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);

        count_next = count;
        case ({up_fire, down_fire})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage is not reset; its contents only matter once count says so.
    always_ff @(posedge clk) begin
        if (up_fire && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, count and the registered handshake outputs. Because ready and
    // valid are computed from count_next, they always match the count the
    // buffer holds after the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ready_up_out   <= 1'b0;
            valid_down_out <= 1'b0;
        end else if (flush) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ready_up_out   <= 1'b1;
            valid_down_out <= 1'b0;
        end else begin
            if (up_fire) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (down_fire) begin
                rd_ptr <= rd_ptr_inc;
            end
            count          <= count_next;
            ready_up_out   <= (count_next != FULL);
            valid_down_out <= (count_next != '0);
        end
    end

    // data_out always shows the head entry. It changes only when the head
    // changes, so it stays stable while the downstream side stalls:
    //  - push into an empty buffer: the new word bypasses storage.
    //  - pop with one entry left and a concurrent push: the pushed word is the
    //    new head, but it is not in mem yet, so take it from data_in.
    //  - pop with two or more entries: the next head is already in mem.
    // mem is never read when the buffer is empty. A flush leaves data_out
    // unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (!flush) begin
            if (up_fire && count == '0) begin
                data_out <= data_in;
            end else if (down_fire && count_next != '0) begin
                if (count == CW'(1)) begin
                    data_out <= data_in;
                end else begin
                    data_out <= mem[rd_ptr_inc];
                end
            end
        end
    end

`ifdef VR_NODE_OCC_EN
    assign occupancy = count;
`endif

endmodule
